// File: rtl/turbo_iter_ctrl.sv
// turbo_iter_ctrl: iteration scheduler for the single shared SISO engine of
// the turbo decoder. Sequences DEC1 (natural order) and DEC2 (interleaved
// order) half-iterations, watches each SISO run with a watchdog and counts
// completed full iterations.
// Optional build macro EARLY_TERM_EN: stop the frame early once the DEC2
// hard decisions repeat across consecutive iterations (after MIN_ITER).
module turbo_iter_ctrl #(
  parameter int MAX_ITER = 16,
  parameter int MIN_ITER = 2,
  parameter int TIMEOUT  = 255,
  parameter int HD_W     = 5
) (
  input  logic            clk_p_i,
  input  logic            reset_n_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            siso_finish_i,
  input  logic [HD_W-1:0] hd_i,
  output logic            siso_start_o,
  output logic            half_o,
  output logic            ext_clr_o,
  output logic            ext_wr_o,
  output logic [5:0]      iter_o,
  output logic [HD_W-1:0] hd_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            early_o,
  output logic            timeout_o
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [5:0]      ITER_MAX = 6'(MAX_ITER);
  localparam logic [5:0]      ITER_MIN = 6'(MIN_ITER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LAUNCH,
    S_WAIT,
    S_UPDATE,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  logic [WD_W-1:0]   wd_cnt;
  logic [HD_W-1:0]   hd_cap;
  logic [5:0]        iter_inc;
  logic              early_stop;

  assign iter_inc = iter_o + 6'd1;

`ifdef EARLY_TERM_EN
  logic [HD_W-1:0]   hd_prev;
  logic              hd_prev_vld;

  // Decisions unchanged since the previous DEC2 pass and enough iterations done
  assign early_stop = hd_prev_vld && (hd_cap == hd_prev) && (iter_inc >= ITER_MIN);
`else
  assign early_stop = 1'b0;
  assign early_o    = 1'b0;
`endif

  // Scheduler FSM; every output pulse is registered on entry to its state
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= S_IDLE;
      wd_cnt       <= '0;
      hd_cap       <= '0;
      siso_start_o <= 1'b0;
      half_o       <= 1'b0;
      ext_clr_o    <= 1'b0;
      ext_wr_o     <= 1'b0;
      iter_o       <= '0;
      hd_o         <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      timeout_o    <= 1'b0;
`ifdef EARLY_TERM_EN
      early_o      <= 1'b0;
      hd_prev      <= '0;
      hd_prev_vld  <= 1'b0;
`endif
    end else begin
      siso_start_o <= 1'b0;
      ext_clr_o    <= 1'b0;
      ext_wr_o     <= 1'b0;
      done_o       <= 1'b0;
      if (abort_i) begin
        // abort beats every other transition; the watchdog error flag survives
        state  <= S_IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i) begin
              state     <= S_CLR;
              ext_clr_o <= 1'b1;
              busy_o    <= 1'b1;
              iter_o    <= '0;
              half_o    <= 1'b0;
              timeout_o <= 1'b0;
`ifdef EARLY_TERM_EN
              early_o   <= 1'b0;
`endif
            end
          end
          S_CLR: begin
            state        <= S_LAUNCH;
            siso_start_o <= 1'b1;
`ifdef EARLY_TERM_EN
            hd_prev_vld  <= 1'b0;
`endif
          end
          S_LAUNCH: begin
            state  <= S_WAIT;
            wd_cnt <= '0;
          end
          S_WAIT: begin
            if (siso_finish_i) begin
              // a finish in the last watchdog cycle still counts as success
              state    <= S_UPDATE;
              hd_cap   <= hd_i;
              ext_wr_o <= 1'b1;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
              if (wd_cnt == WD_LAST) begin
                state     <= S_ERR;
                timeout_o <= 1'b1;
              end
            end
          end
          S_UPDATE: begin
            if (!half_o) begin
              half_o       <= 1'b1;
              state        <= S_LAUNCH;
              siso_start_o <= 1'b1;
            end else begin
              iter_o <= iter_inc;
              hd_o   <= hd_cap;
              if (iter_inc == ITER_MAX) begin
                state  <= S_DONE;
                done_o <= 1'b1;
              end else if (early_stop) begin
                state   <= S_DONE;
                done_o  <= 1'b1;
`ifdef EARLY_TERM_EN
                early_o <= 1'b1;
`endif
              end else begin
`ifdef EARLY_TERM_EN
                hd_prev     <= hd_cap;
                hd_prev_vld <= 1'b1;
`endif
                half_o       <= 1'b0;
                state        <= S_LAUNCH;
                siso_start_o <= 1'b1;
              end
            end
          end
          S_DONE: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
          S_ERR: begin
            state <= S_ERR;
          end
          default: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// tb_turbo_iter_ctrl: randomized bench for turbo_iter_ctrl with a
// frame-level reference model (iterations, early stop, pulse counts).
module tb_turbo_iter_ctrl;

  localparam int MAX_ITER = 3;
  localparam int MIN_ITER = 2;
  localparam int TIMEOUT  = 10;
  localparam int HD_W     = 5;
`ifdef EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic            clk_p_i = 1'b0;
  logic            reset_n_i = 1'b0;
  logic            start_i = 1'b0;
  logic            abort_i = 1'b0;
  logic            siso_finish_i = 1'b0;
  logic [HD_W-1:0] hd_i = '0;
  logic            siso_start_o;
  logic            half_o;
  logic            ext_clr_o;
  logic            ext_wr_o;
  logic [5:0]      iter_o;
  logic [HD_W-1:0] hd_o;
  logic            busy_o;
  logic            done_o;
  logic            early_o;
  logic            timeout_o;

  int checks = 0;
  int failures = 0;
  int n_start = 0;
  int n_clr = 0;
  int n_wr = 0;
  int n_done = 0;
  logic half_q[$];

  always #5 clk_p_i = ~clk_p_i;

  turbo_iter_ctrl #(
    .MAX_ITER(MAX_ITER),
    .MIN_ITER(MIN_ITER),
    .TIMEOUT (TIMEOUT),
    .HD_W    (HD_W)
  ) dut (
    .clk_p_i      (clk_p_i),
    .reset_n_i    (reset_n_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .siso_finish_i(siso_finish_i),
    .hd_i         (hd_i),
    .siso_start_o (siso_start_o),
    .half_o       (half_o),
    .ext_clr_o    (ext_clr_o),
    .ext_wr_o     (ext_wr_o),
    .iter_o       (iter_o),
    .hd_o         (hd_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .early_o      (early_o),
    .timeout_o    (timeout_o)
  );

  // pulse monitor, sampled on the inactive edge
  always @(negedge clk_p_i) begin
    if (reset_n_i) begin
      if (siso_start_o) begin
        n_start <= n_start + 1;
        half_q.push_back(half_o);
      end
      if (ext_clr_o) n_clr  <= n_clr + 1;
      if (ext_wr_o)  n_wr   <= n_wr + 1;
      if (done_o)    n_done <= n_done + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // wait for a launch (ev=1) or a done pulse (ev=2), bounded
  task automatic wait_evt(output int ev);
    bit seen;
    seen = 1'b0;
    ev = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk_p_i);
      if (siso_start_o) begin
        ev = 1;
        seen = 1'b1;
      end else if (done_o) begin
        ev = 2;
        seen = 1'b1;
      end
    end
    if (!seen) chk("wait_bound", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk_p_i);
    start_i = 1'b1;
    @(negedge clk_p_i);
    start_i = 1'b0;
  endtask

  // mode 0: constant DEC2 hd, 1: alternating, 2: random 0/1
  task automatic run_frame(input int mode, input int lat_fix, input bit inject);
    logic [HD_W-1:0] hd2[MAX_ITER];
    int exp_iter, launches, ev, lat, b_start, b_clr, b_wr, b_done, qb;
    bit exp_early, stop, done;
    for (int i = 0; i < MAX_ITER; i++) begin
      case (mode)
        0:       hd2[i] = 5'b10110;
        1:       hd2[i] = (i % 2 == 0) ? 5'b00001 : 5'b00010;
        default: hd2[i] = HD_W'($urandom_range(0, 1));
      endcase
    end
    exp_iter = 0;
    exp_early = 1'b0;
    stop = 1'b0;
    for (int it = 1; it <= MAX_ITER && !stop; it++) begin
      exp_iter = it;
      if (it == MAX_ITER) stop = 1'b1;
      else if (EARLY && it >= 2 && it >= MIN_ITER && hd2[it-1] == hd2[it-2]) begin
        stop = 1'b1;
        exp_early = 1'b1;
      end
    end
    b_start = n_start; b_clr = n_clr; b_wr = n_wr; b_done = n_done;
    qb = half_q.size();
    if (inject) begin
      @(negedge clk_p_i);
      siso_finish_i = 1'b1;
      @(negedge clk_p_i);
      siso_finish_i = 1'b0;
      chk("idle_finish_busy", 32'(busy_o), 32'd0);
    end
    pulse_start();
    chk("clr_pulse", 32'(ext_clr_o), 32'd1);
    chk("start_busy", 32'(busy_o), 32'd1);
    chk("start_tmo_clr", 32'(timeout_o), 32'd0);
    chk("start_early_clr", 32'(early_o), 32'd0);
    chk("start_iter_clr", 32'(iter_o), 32'd0);
    launches = 0;
    done = 1'b0;
    while (!done && launches < 2 * MAX_ITER + 4) begin
      wait_evt(ev);
      if (ev == 1) begin
        lat = (lat_fix > 0) ? lat_fix : $urandom_range(1, 8);
        for (int c = 0; c < lat; c++) begin
          @(negedge clk_p_i);
          start_i = (inject && launches == 0 && c == 0);
        end
        start_i = 1'b0;
        siso_finish_i = 1'b1;
        hd_i = (launches % 2 == 1) ? hd2[launches / 2] : HD_W'($urandom_range(0, 31));
        @(negedge clk_p_i);
        siso_finish_i = 1'b0;
        hd_i = HD_W'($urandom_range(0, 31));
        launches++;
      end else if (ev == 2) begin
        done = 1'b1;
      end else begin
        launches = 2 * MAX_ITER + 4;
      end
    end
    repeat (2) @(negedge clk_p_i);
    chk("launches", 32'(n_start - b_start), 32'(2 * exp_iter));
    chk("ext_wr_cnt", 32'(n_wr - b_wr), 32'(2 * exp_iter));
    chk("ext_clr_cnt", 32'(n_clr - b_clr), 32'd1);
    chk("done_cnt", 32'(n_done - b_done), 32'd1);
    chk("iter", 32'(iter_o), 32'(exp_iter));
    chk("hd_out", 32'(hd_o), 32'(hd2[exp_iter-1]));
    chk("early", 32'(early_o), 32'(exp_early));
    chk("end_busy", 32'(busy_o), 32'd0);
    for (int i = qb; i < half_q.size(); i++) chk("half_seq", 32'(half_q[i]), 32'((i - qb) % 2));
  endtask

  task automatic run_timeout();
    int ev, cnt, b_start;
    b_start = n_start;
    pulse_start();
    wait_evt(ev);
    chk("tmo_launch", 32'(ev), 32'd1);
    cnt = 0;
    while (!timeout_o && cnt < 20) begin
      @(negedge clk_p_i);
      cnt++;
    end
    chk("tmo_cycles", 32'(cnt), 32'(TIMEOUT + 1));
    chk("tmo_busy", 32'(busy_o), 32'd1);
    repeat (20) @(negedge clk_p_i);
    chk("tmo_no_launch", 32'(n_start - b_start), 32'd1);
    chk("tmo_sticky", 32'(timeout_o), 32'd1);
    abort_i = 1'b1;
    @(negedge clk_p_i);
    abort_i = 1'b0;
    chk("tmo_abort_idle", 32'(busy_o), 32'd0);
    chk("tmo_kept", 32'(timeout_o), 32'd1);
  endtask

  task automatic run_abort();
    int ev, b_start, b_wr, b_done;
    b_start = n_start; b_wr = n_wr; b_done = n_done;
    pulse_start();
    wait_evt(ev);
    repeat (2) @(negedge clk_p_i);
    siso_finish_i = 1'b1;
    abort_i = 1'b1;
    @(negedge clk_p_i);
    siso_finish_i = 1'b0;
    abort_i = 1'b0;
    chk("abort_idle", 32'(busy_o), 32'd0);
    repeat (4) @(negedge clk_p_i);
    chk("abort_no_wr", 32'(n_wr - b_wr), 32'd0);
    chk("abort_no_done", 32'(n_done - b_done), 32'd0);
    chk("abort_launches", 32'(n_start - b_start), 32'd1);
  endtask

  task automatic run_reset();
    int ev, b_start;
    b_start = n_start;
    pulse_start();
    wait_evt(ev);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_launch", 32'(siso_start_o), 32'd0);
    chk("rst_half", 32'(half_o), 32'd0);
    @(negedge clk_p_i);
    reset_n_i = 1'b1;
    repeat (6) @(negedge clk_p_i);
    chk("rst_no_pulse", 32'(n_start - b_start), 32'd1);
    chk("rst_idle", 32'(busy_o), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk_p_i);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_iter", 32'(iter_o), 32'd0);
    chk("reset_hd", 32'(hd_o), 32'd0);
    chk("reset_pulses", {28'd0, siso_start_o, ext_clr_o, ext_wr_o, done_o}, 32'd0);
    chk("reset_flags", {29'd0, half_o, early_o, timeout_o}, 32'd0);
    reset_n_i = 1'b1;
    run_frame(1, 4, 1'b0);
    run_frame(0, 0, 1'b0);
    run_frame(1, 4, 1'b1);
    run_timeout();
    run_frame(2, 0, 1'b0);
    run_abort();
    for (int k = 0; k < 6; k++) run_frame(2, 0, 1'b0);
    run_reset();
    run_frame(0, 0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/turbo_iter_ctrl.md
Name: turbo_iter_ctrl

Overview:
Iteration scheduler for the single shared SISO engine of the turbo decoder. After a frame is loaded, it sequences the half-iterations: DEC1 in natural order, then DEC2 in interleaved order. It issues launch pulses, waits on the SISO finish flag with a watchdog, and counts full iterations. With the optional feature enabled, it terminates early when hard decisions stop changing. The surrounding decoder top routes its sys/enc/ext muxes from half_o and latches extrinsics on ext_wr_o.

Parameters:
- MAX_ITER, 16, full iterations (DEC1+DEC2 pairs) before forced stop; legal range 1..63.
- MIN_ITER, 2, minimum full iterations before early termination is allowed.
- TIMEOUT, 255, WAIT-state cycles without siso_finish_i before the error state.
- HD_W, 5, hard-decision width (equals the frame input_size).

Ports:
- clk_p_i, input, 1, clock; all state updates on the rising edge.
- reset_n_i, input, 1, reset; asynchronous, active-low.
- start_i, input, 1, frame loaded; sampled only in IDLE.
- abort_i, input, 1, synchronous abort; takes effect from any state.
- siso_finish_i, input, 1, SISO half-iteration complete; honoured only in WAIT.
- hd_i, input, HD_W, SISO hard decisions; valid in the same cycle as siso_finish_i.
- siso_start_o, output, 1, one-cycle SISO launch pulse (drives read_en).
- half_o, output, 1, 0 = DEC1 natural order, 1 = DEC2 interleaved order.
- ext_clr_o, output, 1, one-cycle clear of extrinsic registers at frame start.
- ext_wr_o, output, 1, one-cycle strobe to latch the new extrinsic LLRs.
- iter_o, output, 6, completed full iterations.
- hd_o, output, HD_W, last captured DEC2 hard decisions.
- busy_o, output, 1, high in every state except IDLE.
- done_o, output, 1, one-cycle pulse on normal completion.
- early_o, output, 1, set when the last frame ended early; held until the next accepted start.
- timeout_o, output, 1, sticky watchdog error; cleared on the next accepted start.

Behaviour:
- States: IDLE, CLR, LAUNCH, WAIT, UPDATE, DONE, ERR. All outputs are registered or decoded from state; no input-to-output combinational path.
- Reset values: state IDLE; all outputs 0; internal hd_prev 0; hd_prev_vld 0; watchdog counter 0.
- IDLE: start_i=1 -> CLR. Also clears early_o and timeout_o, and sets iter_o=0 and half_o=0.
- CLR: ext_clr_o=1; hd_prev_vld<=0; -> LAUNCH.
- LAUNCH: siso_start_o=1; watchdog<=0; -> WAIT.
- WAIT:
  - siso_finish_i=1: hd_cap<=hd_i; -> UPDATE.
  - Otherwise watchdog increments; reaching TIMEOUT -> ERR.
  - siso_finish_i and timeout in the same cycle: finish wins.
- UPDATE: ext_wr_o=1.
  - If half_o=0: half_o<=1; -> LAUNCH.
  - If half_o=1: iter_o<=iter_o+1 and hd_o<=hd_cap, then:
    - iter_o+1 == MAX_ITER -> DONE.
    - Early-stop condition (see Optional Feature) -> DONE, early_o<=1.
    - Otherwise: hd_prev<=hd_cap; hd_prev_vld<=1; half_o<=0; -> LAUNCH.
- DONE: done_o=1 for one cycle; -> IDLE. hd_o and iter_o hold until the next start.
- ERR: timeout_o=1; busy_o stays 1; no SISO launches. Leaves only on abort_i.
- abort_i in any state -> IDLE on the next edge.
  - No done_o and no ext_wr_o are issued.
  - timeout_o is kept.
  - abort_i has priority over every other transition.
- Ignored inputs:
  - start_i while busy_o=1.
  - siso_finish_i outside WAIT.
- Latency: start_i sampled at edge 0 -> ext_clr_o in cycle 1 -> siso_start_o in cycle 2. finish sampled at edge k -> ext_wr_o in cycle k+1 -> next siso_start_o in cycle k+2.
- Total SISO launches per non-early frame = 2*MAX_ITER.
- Reset asserted mid-frame: immediate return to reset values; no further pulses.

Optional Feature:
- Macro: EARLY_TERM_EN.
- Defined: at a DEC2 UPDATE, stop early when all of the following hold:
  - hd_prev_vld=1,
  - hd_cap == hd_prev,
  - iter_o+1 >= MIN_ITER.
- On early stop, set early_o and go to DONE.
- Undefined: the comparator and hd_prev are removed; early_o is tied 0; every frame runs exactly MAX_ITER iterations.

Test Plan:
- MAX_ITER=3, SISO model finishes 4 cycles after each launch -> exactly 6 siso_start_o pulses; half_o sequence 0,1,0,1,0,1; 6 ext_wr_o; one ext_clr_o; done_o once; iter_o=3.
- EARLY_TERM_EN, MAX_ITER=16, MIN_ITER=2, hd_i=5'b10110 at every DEC2 finish -> done_o after iteration 2 (4 launches); early_o=1; hd_o=5'b10110.
- EARLY_TERM_EN, hd_i alternates 5'b00001/5'b00010 at each DEC2 finish, MAX_ITER=4 -> runs all 4 iterations; early_o=0.
- TIMEOUT=10, SISO never finishes -> timeout_o=1 after 10 WAIT cycles, busy_o=1, no further pulses. Then abort_i -> IDLE with timeout_o still 1. Then start_i -> timeout_o cleared and a new frame runs.
- start_i pulsed during WAIT, plus siso_finish_i pulsed in IDLE -> both ignored; launch count unchanged.
- abort_i in the same cycle as siso_finish_i in WAIT -> IDLE next cycle; no ext_wr_o; no done_o.
